// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension pipeline: mode encodings,
// instruction field positions and the raw-field selector used at stage entry.
package imm_ext_pkg;

  localparam logic [2:0] MODE_ALU_IMM   = 3'd0;
  localparam logic [2:0] MODE_DT_ADDR   = 3'd1;
  localparam logic [2:0] MODE_BR_ADDR   = 3'd2;
  localparam logic [2:0] MODE_CB_ADDR   = 3'd3;
  localparam logic [2:0] MODE_MOVW      = 3'd4;
  localparam logic [2:0] MODE_ALU_IMM12 = 3'd5;

  // Widest raw field is the 26-bit branch offset; all fields are right-aligned.
  localparam int RAW_W       = 26;
  localparam int ALU_LSB     = 10;
  localparam int ALU_W       = 12;
  localparam int DT_LSB      = 12;
  localparam int DT_W        = 9;
  localparam int BR_LSB      = 0;
  localparam int BR_W        = 26;
  localparam int CB_LSB      = 5;
  localparam int CB_W        = 19;
  localparam int MOVW_LSB    = 5;
  localparam int MOVW_W      = 18;
  localparam int MOVW_HW_LSB = 21;
  localparam int ALU12_SHIFT = 12;

  // MOVW keeps its 2-bit halfword selector above the 16-bit immediate.
  function automatic logic [RAW_W-1:0] select_field(input logic [31:0] instr,
                                                    input logic [2:0]  mode);
    logic [RAW_W-1:0] f;
    f = '0;
    case (mode)
      MODE_ALU_IMM, MODE_ALU_IMM12: f[ALU_W-1:0]  = instr[ALU_LSB +: ALU_W];
      MODE_DT_ADDR:                 f[DT_W-1:0]   = instr[DT_LSB +: DT_W];
      MODE_BR_ADDR:                 f[BR_W-1:0]   = instr[BR_LSB +: BR_W];
      MODE_CB_ADDR:                 f[CB_W-1:0]   = instr[CB_LSB +: CB_W];
      MODE_MOVW:                    f[MOVW_W-1:0] = instr[MOVW_LSB +: MOVW_W];
      default:                      f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational extension/shift/PC-add of a pre-selected raw immediate field.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter bit PCREL  = 1'b0
) (
  input  logic [RAW_W-1:0]  raw,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] pc,
  input  logic              err_in,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  logic signed [DATA_W-1:0] dt_ext;
  logic signed [DATA_W-1:0] br_ext;
  logic signed [DATA_W-1:0] cb_ext;
  logic signed [DATA_W-1:0] br_tgt;
  logic signed [DATA_W-1:0] cb_tgt;
  logic        [DATA_W-1:0] alu_ext;
  logic        [DATA_W-1:0] alu12_ext;
  logic        [DATA_W-1:0] movw_ext;

  assign dt_ext    = {{(DATA_W-DT_W){raw[DT_W-1]}}, raw[DT_W-1:0]};
  assign br_ext    = {{(DATA_W-BR_W-2){raw[BR_W-1]}}, raw[BR_W-1:0], 2'b00};
  assign cb_ext    = {{(DATA_W-CB_W-2){raw[CB_W-1]}}, raw[CB_W-1:0], 2'b00};
  assign alu_ext   = {{(DATA_W-ALU_W){1'b0}}, raw[ALU_W-1:0]};
  assign alu12_ext = {{(DATA_W-ALU_W-ALU12_SHIFT){1'b0}}, raw[ALU_W-1:0], {ALU12_SHIFT{1'b0}}};
  // Shift amount is 16*hw; illegal hw values never reach here (err_in is set).
  assign movw_ext  = {{(DATA_W-16){1'b0}}, raw[15:0]} << {raw[17:16], 4'b0000};

  // Two's-complement wrap discards the carry, giving the mod-2^DATA_W target.
  assign br_tgt = $signed(pc) + br_ext;
  assign cb_tgt = $signed(pc) + cb_ext;

  always_comb begin
    data = '0;
    err  = err_in;
    if (!err_in) begin
      case (mode)
        MODE_ALU_IMM:   data = alu_ext;
        MODE_DT_ADDR:   data = dt_ext;
        MODE_BR_ADDR:   data = PCREL ? br_tgt : br_ext;
        MODE_CB_ADDR:   data = PCREL ? cb_tgt : cb_ext;
        MODE_MOVW:      data = movw_ext;
        MODE_ALU_IMM12: data = alu12_ext;
        default:        err  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage immediate-extension pipeline with valid/ready on both sides.
// S1 holds the raw field and early error; S2 holds the final operand.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter bit PCREL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [2:0]        in_mode,
  input  logic [DATA_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  localparam logic [2:0] HW_LIM = 3'(DATA_W / 16);

  logic              s1_load;
  logic              s2_load;
  logic              err_p0;
  logic [RAW_W-1:0]  raw_p0;

  logic              vld_p1;
  logic [RAW_W-1:0]  raw_p1;
  logic [2:0]        mode_p1;
  logic [DATA_W-1:0] pc_p1;
  logic              err_p1;

  logic              vld_p2;
  logic [DATA_W-1:0] data_p2;
  logic              err_p2;

  logic [DATA_W-1:0] core_data;
  logic              core_err;

  assign s2_load  = !vld_p2 || out_ready;
  assign s1_load  = !vld_p1 || s2_load;
  assign in_ready = s1_load;

  assign raw_p0 = select_field(in_instr, in_mode);
  assign err_p0 = (in_mode > MODE_ALU_IMM12) ||
                  ((in_mode == MODE_MOVW) &&
                   ({1'b0, in_instr[MOVW_HW_LSB +: 2]} >= HW_LIM));

  // ---- stage boundary p0 -> p1 ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (s1_load) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load && in_valid) begin
      raw_p1  <= raw_p0;
      mode_p1 <= in_mode;
      pc_p1   <= in_pc;
      err_p1  <= err_p0;
    end
  end

  imm_ext_core #(
    .DATA_W (DATA_W),
    .PCREL  (PCREL)
  ) u_core (
    .raw    (raw_p1),
    .mode   (mode_p1),
    .pc     (pc_p1),
    .err_in (err_p1),
    .data   (core_data),
    .err    (core_err)
  );

  // ---- stage boundary p1 -> p2 ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      err_p2  <= 1'b0;
    end else if (s2_load) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        data_p2 <= core_data;
        err_p2  <= core_err;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_data  = data_p2;
  assign out_err   = err_p2;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: a 64-bit PC-relative instance and a 32-bit plain
// instance share one stimulus stream and are scored against a reference model.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [2:0]  in_mode = '0;
  logic [63:0] in_pc = '0;

  logic        in_ready_a, out_valid_a, out_err_a;
  logic [63:0] out_data_a;
  logic        in_ready_b, out_valid_b, out_err_b;
  logic [31:0] out_data_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [64:0] q[2][$];
  logic [64:0] held[2];
  logic        stall[2];

  always #5 clk = ~clk;

  imm_ext_pipe #(.DATA_W(64), .PCREL(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .in_mode(in_mode), .in_pc(in_pc),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .out_err(out_err_a)
  );

  imm_ext_pipe #(.DATA_W(32), .PCREL(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .in_mode(in_mode), .in_pc(in_pc[31:0]),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .out_err(out_err_b)
  );

  task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: {err, data} from the mode rules with plain integer arithmetic.
  function automatic logic [64:0] ref_model(input logic [31:0] instr, input logic [2:0] mode,
                                            input logic [63:0] pc, input int dw, input bit pcrel);
    longint v;
    bit     err;
    int     hw;
    v   = 0;
    err = 1'b0;
    hw  = int'(instr[22:21]);
    case (mode)
      3'd0: v = longint'(instr[21:10]);
      3'd1: begin v = longint'(instr[20:12]); if (v >= 256) v -= 512; end
      3'd2: begin v = longint'(instr[25:0]) * 4; if (v >= 64'sd134217728) v -= 64'sd268435456; end
      3'd3: begin v = longint'(instr[23:5]) * 4; if (v >= 64'sd1048576) v -= 64'sd2097152; end
      3'd4: if (16 * hw >= dw) err = 1'b1; else v = longint'(instr[20:5]) << (16 * hw);
      3'd5: v = longint'(instr[21:10]) * 4096;
      default: err = 1'b1;
    endcase
    if (err) v = 0;
    else if (pcrel && (mode == 3'd2 || mode == 3'd3)) v = v + longint'(pc);
    if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return {err, 64'(v)};
  endfunction

  // Scoreboard: push on accept, pop on drain, enforce hold while stalled.
  always @(negedge clk) begin
    logic [64:0] got[2];
    logic [64:0] exp;
    logic        ov[2];
    logic        ir[2];
    ov[0]  = out_valid_a;  ov[1] = out_valid_b;
    ir[0]  = in_ready_a;   ir[1] = in_ready_b;
    got[0] = {out_err_a, out_data_a};
    got[1] = {out_err_b, 32'd0, out_data_b};
    if (!rst_n) begin
      q[0].delete();
      q[1].delete();
      stall[0] = 1'b0;
      stall[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (stall[d]) begin
          check($sformatf("dut%0d hold_valid", d), {64'd0, ov[d]}, 65'd1);
          check($sformatf("dut%0d hold_data", d), got[d], held[d]);
        end
        if (ov[d] && out_ready) begin
          if (q[d].size() == 0) begin
            check($sformatf("dut%0d unexpected_out", d), {64'd0, ov[d]}, 65'd0);
          end else begin
            exp = q[d].pop_front();
            check($sformatf("dut%0d result", d), got[d], exp);
          end
        end
        stall[d] = ov[d] && !out_ready;
        held[d]  = got[d];
        if (in_valid && ir[d])
          q[d].push_back(ref_model(in_instr, in_mode, in_pc, (d == 0) ? 64 : 32, d == 0));
      end
    end
  end

  task automatic rand_beat();
    in_instr = $urandom;
    in_mode  = 3'($urandom_range(0, 7));
    in_pc    = {$urandom, $urandom};
  endtask

  task automatic one_beat(input string nm, input logic [31:0] instr, input logic [2:0] mode,
                          input logic [63:0] pc, input logic [63:0] xa, input logic xea,
                          input logic [31:0] xb, input logic xeb);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = instr;
    in_mode   = mode;
    in_pc     = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rand_beat();
    check({nm, " lat1_valid"}, {64'd0, out_valid_a}, 65'd0);
    @(posedge clk); #1;
    check({nm, " lat2_valid"}, {64'd0, out_valid_a}, 65'd1);
    check({nm, " a"}, {out_err_a, out_data_a}, {xea, xa});
    check({nm, " b"}, {out_err_b, 32'd0, out_data_b}, {xeb, 32'd0, xb});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nacc;
    logic [63:0] held_bp;

    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", {64'd0, out_valid_a}, 65'd0);
    check("rst out_data", {out_err_a, out_data_a}, 65'd0);
    check("rst in_ready", {64'd0, in_ready_a}, 65'd1);
    check("rst b", {out_valid_b, out_err_b, 31'd0, out_data_b}, 65'd0);
    rst_n = 1'b1;

    one_beat("alu_imm", 32'h003F_FC00, 3'd0, 64'h0,
             64'h0000_0000_0000_0FFF, 1'b0, 32'h0000_0FFF, 1'b0);
    one_beat("dt_addr", 32'h001F_F000, 3'd1, 64'h0,
             64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0);
    one_beat("cb_addr", 32'h0080_0000, 3'd3, 64'h0,
             64'hFFFF_FFFF_FFF0_0000, 1'b0, 32'hFFF0_0000, 1'b0);
    one_beat("br_pcrel", 32'h0200_0000, 3'd2, 64'h1000,
             64'hFFFF_FFFF_F800_1000, 1'b0, 32'hF800_0000, 1'b0);
    one_beat("movw_hw2", 32'h0055_79A0, 3'd4, 64'h0,
             64'h0000_ABCD_0000_0000, 1'b0, 32'h0, 1'b1);
    one_beat("mode7", 32'hFFFF_FFFF, 3'd7, 64'h1234,
             64'h0, 1'b1, 32'h0, 1'b1);
    check("model movw64", ref_model(32'h0055_79A0, 3'd4, 64'h0, 64, 1'b0),
          {1'b0, 64'h0000_ABCD_0000_0000});
    check("model br_pcrel", ref_model(32'h0200_0000, 3'd2, 64'h1000, 64, 1'b1),
          {1'b0, 64'hFFFF_FFFF_F800_1000});

    in_valid = 1'b0;
    @(posedge clk); #1;

    // Backpressure: 4 beats offered, consumer stalled for 5 cycles.
    out_ready = 1'b0;
    nacc = 0;
    held_bp = '0;
    for (int c = 0; c < 10; c++) begin
      if (c == 5) out_ready = 1'b1;
      in_valid = (nacc < 4);
      if (in_valid) rand_beat();
      @(negedge clk);
      if (c == 2) begin
        check("bp in_ready", {64'd0, in_ready_a}, 65'd0);
        check("bp accepted", 65'(nacc), 65'd2);
        held_bp = out_data_a;
      end
      if (c == 3 || c == 4) check("bp stable", {1'b0, out_data_a}, {1'b0, held_bp});
      if (c >= 5 && c <= 8) check("bp nogap", {64'd0, out_valid_a}, 65'd1);
      if (c == 9) check("bp empty", {64'd0, out_valid_a}, 65'd0);
      if (in_valid && in_ready_a) nacc++;
      @(posedge clk); #1;
    end
    check("bp total", 65'(nacc), 65'd4);

    // Fill both stages, then reset.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_beat();
    @(posedge clk); #1;
    rand_beat();
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full in_ready", {64'd0, in_ready_a}, 65'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst out_valid", {64'd0, out_valid_a}, 65'd0);
    check("midrst out_data", {out_err_a, out_data_a}, 65'd0);
    check("midrst in_ready", {64'd0, in_ready_a}, 65'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("midrst no_stale", {63'd0, out_valid_a, out_valid_b}, 65'd0);
    end

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      rand_beat();
      @(posedge clk); #1;
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("drain a", 65'(q[0].size()), 65'd0);
    check("drain b", 65'(q[1].size()), 65'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
